// File: rtl/dlx_bus_slave.sv
// dlx_bus_slave: DLX-side bus slave with a 256 x 32 word memory, a host
// preload port and a strobe-driven IDLE/WAIT/ACK/RECOVER handshake.
// Build option: define WAIT_STATE_EN to insert WAIT_CYC wait states per
// access; without it every access completes with zero wait states.
module dlx_bus_slave (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AS_N,
    input  logic        WR_N,
    input  logic [31:0] AO,
    input  logic [31:0] DO,
    output logic [31:0] DI,
    output logic        ACK_N,
    output logic        BUSY,
    input  logic [3:0]  WAIT_CYC,
    input  logic        LD_WE,
    input  logic [7:0]  LD_ADDR,
    input  logic [31:0] LD_DATA
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        wr_n_q;
    logic [31:0] data_q;
    logic [31:0] di_q;
    logic        ack_n_q;
    logic        busy_q;
    logic        cnt_zero_s;
    logic        commit_s;
    logic        in_range_s;
    logic [31:0] mem [0:255];

`ifdef WAIT_STATE_EN
    logic [3:0]  cnt_q, cnt_d;

    // The wait counter has expired when it reaches zero.
    always_comb begin
        cnt_zero_s = (cnt_q == 4'd0);
    end
`else
    logic        unused_wait_s;

    // Zero wait states: the WAIT state always completes on its first edge.
    always_comb begin
        cnt_zero_s    = 1'b1;
        unused_wait_s = ^WAIT_CYC;
    end
`endif

    // Next-state logic for the bus handshake, including the wait counter.
    always_comb begin
        state_d = state_q;
`ifdef WAIT_STATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!AS_N) begin
                    state_d = S_WAIT;
`ifdef WAIT_STATE_EN
                    cnt_d   = WAIT_CYC;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (AS_N) begin
                    // Strobe withdrawn: abandon the access silently.
                    state_d = S_IDLE;
`ifdef WAIT_STATE_EN
                    cnt_d   = 4'd0;
`endif
                end else if (cnt_zero_s) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
`ifdef WAIT_STATE_EN
                    cnt_d   = cnt_q - 4'd1;
`endif
                end
            end
            S_ACK: begin
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                // A strobe still held low must not start a second access.
                if (AS_N) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RECOVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // An access completes on the edge that moves WAIT into ACK.
    always_comb begin
        commit_s   = (state_q == S_WAIT) && (state_d == S_ACK);
        in_range_s = (addr_q[31:8] == 24'd0);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wr_n_q  <= 1'b1;
            data_q  <= 32'd0;
            di_q    <= 32'd0;
            ack_n_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && !AS_N) begin
                addr_q <= AO;
                wr_n_q <= WR_N;
                data_q <= DO;
            end
            if (commit_s && wr_n_q) begin
                // Out-of-range reads still complete but return zero.
                di_q <= in_range_s ? mem[addr_q[7:0]] : 32'd0;
            end
            ack_n_q <= (state_d != S_ACK);
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef WAIT_STATE_EN
    // Wait-state counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Memory writes: loader first so a same-address bus write overrides it.
    always_ff @(posedge CLK) begin
        if (LD_WE) begin
            mem[LD_ADDR] <= LD_DATA;
        end
        if (commit_s && !wr_n_q && in_range_s) begin
            mem[addr_q[7:0]] <= data_q;
        end
    end

    assign DI    = di_q;
    assign ACK_N = ack_n_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_dlx_bus_slave.sv
// tb_dlx_bus_slave: directed stimulus for dlx_bus_slave with a scoreboard.
// The driver pushes the expected ACK cycle and DI value for each access;
// a negedge monitor pops and compares whenever ACK_N is low.
module tb_dlx_bus_slave;

    logic        CLK;
    logic        RESET;
    logic        AS_N;
    logic        WR_N;
    logic [31:0] AO;
    logic [31:0] DO;
    logic [31:0] DI;
    logic        ACK_N;
    logic        BUSY;
    logic [3:0]  WAIT_CYC;
    logic        LD_WE;
    logic [7:0]  LD_ADDR;
    logic [31:0] LD_DATA;

    typedef struct {
        logic [31:0] di;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [31:0] exp_di = 32'd0;

    dlx_bus_slave dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .AS_N     (AS_N),
        .WR_N     (WR_N),
        .AO       (AO),
        .DO       (DO),
        .DI       (DI),
        .ACK_N    (ACK_N),
        .BUSY     (BUSY),
        .WAIT_CYC (WAIT_CYC),
        .LD_WE    (LD_WE),
        .LD_ADDR  (LD_ADDR),
        .LD_DATA  (LD_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every low ACK_N cycle must match the oldest expected access.
    always @(negedge CLK) begin
        if (!RESET && ACK_N === 1'b0) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ACK_N=0 expected 1 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_cycle", cyc, e.cyc);
                check("di", DI, e.di);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        LD_WE   = 1'b1;
        LD_ADDR = a;
        LD_DATA = d;
        tick();
        LD_WE   = 1'b0;
    endtask

    function automatic int eff_wait(input logic [3:0] wc);
`ifdef WAIT_STATE_EN
        return int'(wc);
`else
        return (wc == 4'd15) ? 0 : 0;
`endif
    endfunction

    // One bus access; optional loader write on the commit edge; optional
    // extra cycles of held strobe after the access completes.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] wc, input logic [31:0] rd_exp, input int hold,
                        input logic ld_en, input logic [7:0] ld_a, input logic [31:0] ld_d);
        int   w;
        exp_t e;
        w        = eff_wait(wc);
        AS_N     = 1'b0;
        WR_N     = !wr;
        AO       = addr;
        DO       = data;
        WAIT_CYC = wc;
        if (!wr) exp_di = rd_exp;
        e.di  = exp_di;
        e.cyc = cyc + w + 2;
        sb_q.push_back(e);
        for (int i = 0; i < w + 1; i++) tick();
        if (ld_en) begin
            LD_WE   = 1'b1;
            LD_ADDR = ld_a;
            LD_DATA = ld_d;
        end
        tick();
        LD_WE = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) check("busy_held", {31'd0, BUSY}, 32'd1);
        AS_N = 1'b1;
        tick();
        tick();
        check("busy_idle", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int w;
        RESET    = 1'b1;
        AS_N     = 1'b1;
        WR_N     = 1'b1;
        AO       = 32'd0;
        DO       = 32'd0;
        WAIT_CYC = 4'd0;
        LD_WE    = 1'b0;
        LD_ADDR  = 8'd0;
        LD_DATA  = 32'd0;
        tick();
        tick();
        check("rst_di", DI, 32'd0);
        check("rst_ack_n", {31'd0, ACK_N}, 32'd1);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b0;
        tick();

        load(8'h05, 32'hDEADBEEF);
        load(8'h00, 32'h0BADF00D);
        load(8'h20, 32'h11223344);
        load(8'h30, 32'h30303030);
        load(8'h07, 32'h77777777);

        // Preloaded read with three wait states.
        xfer(1'b0, 32'h5, 32'd0, 4'd3, 32'hDEADBEEF, 0, 1'b0, 8'd0, 32'd0);
        // Zero-wait write then read back.
        xfer(1'b1, 32'h10, 32'h12345678, 4'd0, 32'd0, 0, 1'b0, 8'd0, 32'd0);
        xfer(1'b0, 32'h10, 32'd0, 4'd0, 32'h12345678, 0, 1'b0, 8'd0, 32'd0);
        // Strobe held ten cycles past ACK: one pulse only.
        xfer(1'b0, 32'h10, 32'd0, 4'd2, 32'h12345678, 10, 1'b0, 8'd0, 32'd0);
        // Out-of-range write is dropped, out-of-range read returns zero.
        xfer(1'b1, 32'h100, 32'hFFFFFFFF, 4'd1, 32'd0, 0, 1'b0, 8'd0, 32'd0);
        xfer(1'b0, 32'h0, 32'd0, 4'd0, 32'h0BADF00D, 0, 1'b0, 8'd0, 32'd0);
        xfer(1'b0, 32'h100, 32'd0, 4'd0, 32'd0, 0, 1'b0, 8'd0, 32'd0);
        // Long wait, write and read back.
        xfer(1'b1, 32'h40, 32'hA5A50F0F, 4'd7, 32'd0, 0, 1'b0, 8'd0, 32'd0);
        xfer(1'b0, 32'h40, 32'd0, 4'd1, 32'hA5A50F0F, 0, 1'b0, 8'd0, 32'd0);
        // Same-edge loader and bus write to 0x7: bus data wins.
        xfer(1'b1, 32'h7, 32'hB0B0B0B0, 4'd2, 32'd0, 0, 1'b1, 8'h07, 32'hC1C1C1C1);
        xfer(1'b0, 32'h7, 32'd0, 4'd0, 32'hB0B0B0B0, 0, 1'b0, 8'd0, 32'd0);
        // Same-edge loader write during a read: read sees old data.
        xfer(1'b0, 32'h5, 32'd0, 4'd1, 32'hDEADBEEF, 0, 1'b1, 8'h05, 32'hCAFEF00D);
        xfer(1'b0, 32'h5, 32'd0, 4'd0, 32'hCAFEF00D, 0, 1'b0, 8'd0, 32'd0);

        // Strobe withdrawn during WAIT: no ACK, no write.
        AS_N     = 1'b0;
        WR_N     = 1'b0;
        AO       = 32'h30;
        DO       = 32'hEEEEEEEE;
        WAIT_CYC = 4'd2;
        tick();
        AS_N = 1'b1;
        tick();
        tick();
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        xfer(1'b0, 32'h30, 32'd0, 4'd0, 32'h30303030, 0, 1'b0, 8'd0, 32'd0);

        // Reset in the middle of a write.
        w        = eff_wait(4'd5);
        AS_N     = 1'b0;
        WR_N     = 1'b0;
        AO       = 32'h20;
        DO       = 32'hAAAA5555;
        WAIT_CYC = 4'd5;
        for (int i = 0; i < ((w >= 3) ? 3 : 1); i++) tick();
        RESET = 1'b1;
        #1;
        check("midrst_ack_n", {31'd0, ACK_N}, 32'd1);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        check("midrst_di", DI, 32'd0);
        exp_di = 32'd0;
        tick();
        RESET = 1'b0;
        AS_N  = 1'b1;
        tick();
        tick();
        xfer(1'b0, 32'h20, 32'd0, 4'd2, 32'h11223344, 0, 1'b0, 8'd0, 32'd0);

        tick();
        tick();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL missing_ack: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dlx_bus_slave.md
DLX_BUS_SLAVE -- requirements
Module: dlx_bus_slave

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: CLK and RESET.
REQ-002 SHALL have ports: CLK in 1 (all state on rising edge); RESET in 1 (async, active-high).
REQ-003 SHALL have ports: AS_N in 1 (address strobe from DLX, active-low); WR_N in 1 (0 = write, 1 = read); AO in 32 (word address); DO in 32 (write data from DLX).
REQ-004 SHALL have ports: DI out 32 (read data to DLX D_IN); ACK_N out 1 (transfer-complete, active-low, registered); BUSY out 1 (transaction in progress).
REQ-005 SHALL have ports: WAIT_CYC in 4 (wait states per access); LD_WE in 1 (host preload write enable); LD_ADDR in 8; LD_DATA in 32.
REQ-006 SHALL contain a 256 x 32 word memory indexed by AO[7:0] or LD_ADDR; contents are not reset.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, ACK and RECOVER.
REQ-008 IDLE: on an edge with AS_N=0, SHALL latch AO, WR_N and DO, load wait counter with W, and go to WAIT.
REQ-009 WAIT: cnt!=0 decrements; cnt==0 goes to ACK; AS_N=1 at any WAIT edge aborts to IDLE with no write and no ACK.
REQ-010 ACK_N SHALL be low for exactly one cycle, the ACK state, first asserted W+1 cycles after the sampling edge.
REQ-011 Write SHALL commit at the edge entering ACK, using latched address and data.
REQ-012 Read data SHALL be registered into DI at the edge entering ACK and held until the next read completes.
REQ-013 ACK SHALL always go to RECOVER; RECOVER SHALL go to IDLE only on an edge with AS_N=1, so a held strobe produces no second transaction.
REQ-014 BUSY SHALL be 1 in WAIT, ACK and RECOVER, and 0 in IDLE.
REQ-015 Out of range, latched AO[31:8]!=0: SHALL still ACK; a write is dropped and a read returns DI=0.
REQ-016 Loader: LD_WE=1 SHALL write LD_DATA to LD_ADDR at that edge, in any state.
REQ-017 A loader write and a bus write committing to the same address on the same edge SHALL resolve with the bus write winning.
REQ-018 A bus read committing at the same edge as a loader write to the same address SHALL return the old contents.
REQ-019 W = 0 SHALL give ACK_N low in the cycle after the sampling edge.

Reset
REQ-020 RESET=1 SHALL immediately force state IDLE, ACK_N=1, DI=0, BUSY=0 and wait counter 0.
REQ-021 Reset mid-transaction SHALL abort it: a pending write is not committed and memory is unchanged.
REQ-022 After RESET falls, the first AS_N=0 edge SHALL start a new transaction normally.

Configuration
REQ-023 The macro WAIT_STATE_EN SHALL select the wait-state behaviour.
REQ-024 With WAIT_STATE_EN defined, SHALL use W = WAIT_CYC, sampled in IDLE at the strobe edge.
REQ-025 Without WAIT_STATE_EN, W SHALL be fixed at 0 and WAIT_CYC ignored; no counter logic is synthesized.

Verification
REQ-026 Load 0x5 with 0xDEADBEEF via LD_WE, then read AO=0x5 with WAIT_CYC=3 -> ACK_N low exactly on the 4th cycle after strobe for 1 cycle, DI=0xDEADBEEF.
REQ-027 Write AO=0x10, DO=0x12345678, WAIT_CYC=0, then read 0x10 -> first ACK next cycle; read returns 0x12345678.
REQ-028 Hold AS_N low 10 cycles after ACK -> exactly one ACK pulse; BUSY stays 1 until AS_N=1, then IDLE.
REQ-029 Write AO=0x100 DO=0xFFFFFFFF, then read 0x00 and 0x100 -> both ACK; 0x00 unchanged; read of 0x100 gives DI=0.
REQ-030 Write 0x20=0xAAAA5555 with WAIT_CYC=5, assert RESET at cycle 3 -> ACK_N=1, BUSY=0 at once; later read of 0x20 returns its prior value.
REQ-031 Same-edge loader write and bus write commit to 0x7 -> memory holds the bus data.
